serial_add_sub: RTL and testbench
=================================

SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; SHALL divide WIDTH evenly. N = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 start  input  1  request pulse; operands sampled when accepted.
REQ-006 A  input  WIDTH  first operand.
REQ-007 B  input  WIDTH  second operand.
REQ-008 M  input  1  mode: 0 = A+B, 1 = A-B.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 S  output  WIDTH  result.
REQ-012 C  output  1  carry out of the MSB; for subtraction, 1 = no borrow.
REQ-013 V  output  1  two's-complement signed overflow.
REQ-014 Z  output  1  high when the final S == 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 SHALL be accepted: A, B and M are latched, the digit counter clears, carry-in is set to M, and the state moves to RUN.
REQ-017 In RUN, start SHALL be ignored and the latched operands SHALL NOT change.
REQ-018 Arithmetic SHALL compute A + (B XOR {WIDTH{M}}) + M, one DIGIT-bit slice per edge, LSB slice first, with the carry registered between slices.
REQ-019 After N RUN edges, the state SHALL move to DONE, with done=1 for exactly one cycle, beginning N edges after the accepting edge.
REQ-020 busy SHALL be 1 in RUN only.
REQ-021 DONE SHALL return to IDLE after one cycle unless start=1, which SHALL be accepted back-to-back (REQ-016).
REQ-022 S, C, V and Z SHALL update only on the edge that enters DONE, and SHALL hold until the next completion or reset.
REQ-023 C SHALL be the carry out of bit WIDTH-1, and V SHALL be the carry into bit WIDTH-1 XOR C.
REQ-024 With DIGIT == WIDTH, latency SHALL be 1 (done on the edge after acceptance).
REQ-025 S SHALL wrap modulo 2^WIDTH unless REQ-030 applies.

Reset
REQ-026 When rst=1 at an edge, the state SHALL go to IDLE, and busy, done, S, C, V and Z SHALL all be 0.
REQ-027 rst SHALL have priority over start; start in the same cycle as rst SHALL be dropped.
REQ-028 A reset during RUN SHALL abort the operation: no done pulse and no result update.

Configuration
REQ-029 Macro ADD_SUB_SAT_EN SHALL select saturation.
REQ-030 When ADD_SUB_SAT_EN is defined and V=1, S SHALL saturate to 0 followed by WIDTH-1 ones if the latched A[WIDTH-1]=0, else to 1 followed by WIDTH-1 zeros. C and V SHALL be unchanged, and Z SHALL be computed on the saturated S.
REQ-031 When ADD_SUB_SAT_EN is undefined, S SHALL be the wrapped result, and no saturation logic SHALL be present.

Verification (WIDTH=8, DIGIT=4, N=2)
REQ-032 A=0x7F, B=0x01, M=0 -> done 2 edges after start; S=0x80 (0x7F if SAT), C=0, V=1, Z=0.
REQ-033 A=0x80, B=0x01, M=1 -> S=0x7F (0x80 if SAT), C=1, V=1; then A=0x00, B=0x01, M=1 -> S=0xFF, C=0, V=0.
REQ-034 A=0x35, B=0x35, M=1 -> S=0x00, C=1, V=0, Z=1.
REQ-035 start re-asserted in RUN with new operands -> ignored, original result reported; start held in the DONE cycle -> second operation accepted, done again 2 edges later.
REQ-036 rst pulsed one edge after acceptance -> busy=0, done=0, S=0, C=V=Z=0 next cycle; no done pulse follows.
REQ-037 Repeat REQ-032 to REQ-034 with DIGIT=1 (N=8) and DIGIT=8 (N=1) -> identical results, with latency of 8 and 1 edges respectively.

Source files
------------

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB slice first, registered carry.
// Define ADD_SUB_SAT_EN to saturate S on signed overflow instead of wrapping.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V,
    output logic             Z
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one DIGIT slice added per edge
    // DONE  | result valid, done pulse; start accepted back-to-back
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic [DIGIT-1:0] a_sl, b_sl;
    logic [DIGIT:0]   sl_sum;
    logic             c_into_msb;
    logic             last_slice;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] s_final;
    int               idx;

    always_comb begin
        idx    = int'(cnt_q) * DIGIT;
        a_sl   = a_q[idx +: DIGIT];
        b_sl   = b_q[idx +: DIGIT];
        sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, cy_q};
        // carry into the slice MSB recovered from its sum bit and operand bits
        c_into_msb = sl_sum[DIGIT-1] ^ a_sl[DIGIT-1] ^ b_sl[DIGIT-1];
        last_slice = (cnt_q == CW'(N - 1));
        r_nx       = r_q;
        r_nx[idx +: DIGIT] = sl_sum[DIGIT-1:0];
`ifdef ADD_SUB_SAT_EN
        if (c_into_msb ^ sl_sum[DIGIT])
            s_final = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
        else
            s_final = r_nx;
`else
        s_final = r_nx;
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        r_d     = r_q;
        s_d     = s_q;
        c_d     = c_q;
        v_d     = v_q;
        z_d     = z_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B ^ {WIDTH{M}};
                    cnt_d   = '0;
                    cy_d    = M;
                    r_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = r_nx;
                cy_d  = sl_sum[DIGIT];
                cnt_d = cnt_q + 1'b1;
                if (last_slice) begin
                    state_d = DONE;
                    s_d     = s_final;
                    c_d     = sl_sum[DIGIT];
                    v_d     = c_into_msb ^ sl_sum[DIGIT];
                    z_d     = ~|s_final;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            r_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign S    = s_q;
    assign C    = c_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: DIGIT=1, 4 and 8 instances (WIDTH=8) driven in parallel,
// checked against a signed/unsigned arithmetic model.
module tb_serial_add_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A, B;
    logic       M;
    logic [2:0] busy_w, done_w, c_w, v_w, z_w;
    logic [7:0] s_w [3];

    int checks   = 0;
    int failures = 0;
    int lat [3]  = '{8, 2, 1};

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .M(M),
        .busy(busy_w[0]), .done(done_w[0]), .S(s_w[0]), .C(c_w[0]), .V(v_w[0]), .Z(z_w[0]));
    serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .M(M),
        .busy(busy_w[1]), .done(done_w[1]), .S(s_w[1]), .C(c_w[1]), .V(v_w[1]), .Z(z_w[1]));
    serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .M(M),
        .busy(busy_w[2]), .done(done_w[2]), .S(s_w[2]), .C(c_w[2]), .V(v_w[2]), .Z(z_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic m,
                                  output logic [7:0] s, output logic c, output logic v,
                                  output logic z);
        int sa = $signed(a);
        int sb = $signed(b);
        int ua = a;
        int ub = b;
        int r  = m ? (sa - sb) : (sa + sb);
        v = (r > 127) || (r < -128);
        c = m ? (ua >= ub) : ((ua + ub) > 255);
        s = r[7:0];
`ifdef ADD_SUB_SAT_EN
        if (v) s = a[7] ? 8'h80 : 8'h7F;
`endif
        z = (s == 8'h00);
    endfunction

    task automatic check_res(input string tag, input int k, input logic [7:0] es,
                             input logic ec, input logic ev, input logic ez);
        check($sformatf("%s S[%0d]", tag, k), s_w[k], es);
        check($sformatf("%s C[%0d]", tag, k), c_w[k], ec);
        check($sformatf("%s V[%0d]", tag, k), v_w[k], ev);
        check($sformatf("%s Z[%0d]", tag, k), z_w[k], ez);
    endtask

    // One operation on all three instances; timing of busy/done checked every cycle.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic m);
        logic [7:0] es;
        logic ec, ev, ez;
        model(a, b, m, es, ec, ev, ez);
        @(negedge clk);
        A = a; B = b; M = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); M = 1'($urandom);
        for (int j = 1; j <= 10; j++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s done[%0d] j%0d", tag, k, j), done_w[k], 32'(j - 1 == lat[k]));
                check($sformatf("%s busy[%0d] j%0d", tag, k, j), busy_w[k], 32'(j - 1 < lat[k]));
                if (j - 1 == lat[k] || j == 10) check_res(tag, k, es, ec, ev, ez);
            end
            if (j < 10) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s busy[%0d]", tag, k), busy_w[k], 0);
            check($sformatf("%s done[%0d]", tag, k), done_w[k], 0);
            check_res(tag, k, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] es;
        logic ec, ev, ez;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; M = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        run_op("add_ovf", 8'h7F, 8'h01, 1'b0);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1);
        run_op("sub_borrow", 8'h00, 8'h01, 1'b1);

        // abort mid-operation: results clear, no done pulse afterwards
        @(negedge clk);
        A = 8'h12; B = 8'h34; M = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared("abort");
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                check($sformatf("abort no_done[%0d] j%0d", k, j), done_w[k], 0);
        end

        // start coinciding with reset is dropped
        @(negedge clk);
        A = 8'h01; B = 8'h01; M = 1'b0; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        for (int k = 0; k < 3; k++)
            check($sformatf("rst_prio busy[%0d]", k), busy_w[k], 0);

        run_op("sub_zero", 8'h35, 8'h35, 1'b1);

        // DIGIT=4 instance: start during RUN ignored, start held in DONE accepted
        @(negedge clk);
        A = 8'h7F; B = 8'h01; M = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 8'h35; B = 8'h35; M = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign done_early", done_w[1], 0);
        @(negedge clk);
        model(8'h7F, 8'h01, 1'b0, es, ec, ev, ez);
        check("ign done", done_w[1], 1);
        check_res("ign", 1, es, ec, ev, ez);
        A = 8'h35; B = 8'h35; M = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 8'hAA; B = 8'h11;
        check("b2b busy", busy_w[1], 1);
        check("b2b done0", done_w[1], 0);
        check_res("b2b hold", 1, es, ec, ev, ez);
        @(negedge clk);
        check("b2b done1", done_w[1], 0);
        @(negedge clk);
        model(8'h35, 8'h35, 1'b1, es, ec, ev, ez);
        check("b2b done2", done_w[1], 1);
        check_res("b2b", 1, es, ec, ev, ez);

        do_reset();
        run_op("edge_ff_add", 8'hFF, 8'hFF, 1'b0);
        run_op("edge_80_sub7f", 8'h80, 8'h7F, 1'b1);
        run_op("edge_00_add", 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 30; i++)
            run_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
